// File: rtl/d_latch_pkg.sv
// Shared constants and helpers for the emulated gated D-latch.
// Used by d_latch and d_latch_cell; feature macro D_LATCH_TRANSPARENT_EN.
package d_latch_pkg;

    localparam int   D_LATCH_WIDTH_DEF = 1;
    localparam logic D_LATCH_RST_VAL   = '0;

    typedef enum logic {
        GATE_HOLD    = 1'b0,
        GATE_CAPTURE = 1'b1
    } gate_e;

    // Next held value for one bit: capture D while the gate is open.
    function automatic logic latch_next(input logic gate, input logic d, input logic held);
        return (gate_e'(gate) == GATE_CAPTURE) ? d : held;
    endfunction

endpackage

// File: rtl/d_latch_cell.sv
// One bit of the gated D-latch, emulated with a clk-domain flop.
// D_LATCH_TRANSPARENT_EN adds a combinational D->Q path while C=1.
module d_latch_cell
    import d_latch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic C,
    input  logic D,
    output logic Q,
    output logic Qbar
);

    logic held_q;
    logic held_d;

    assign held_d = latch_next(C, D, held_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= D_LATCH_RST_VAL;
        end else begin
            held_q <= held_d;
        end
    end

`ifdef D_LATCH_TRANSPARENT_EN
    // Reset must win over the open gate, otherwise D would leak out during reset.
    assign Q = !rst_n ? D_LATCH_RST_VAL : (C ? D : held_q);
`else
    assign Q = held_q;
`endif

    assign Qbar = ~Q;

endmodule

// File: rtl/d_latch.sv
// WIDTH-bit gated D-latch built from independent cells sharing gate C.
// Optional macro D_LATCH_TRANSPARENT_EN selects the transparent output mux.
module d_latch
    import d_latch_pkg::*;
#(
    parameter int WIDTH = D_LATCH_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             C,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar
);

    typedef logic [WIDTH-1:0] latch_word_t;

    latch_word_t q_w;
    latch_word_t qbar_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_latch_cell u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .C    (C),
            .D    (D[i]),
            .Q    (q_w[i]),
            .Qbar (qbar_w[i])
        );
    end

    assign Q    = q_w;
    assign Qbar = qbar_w;

endmodule

// File: tb/tb_d_latch.sv
// Directed bench for d_latch: a WIDTH=1 and a WIDTH=8 instance share clk/rst_n.
// Honours D_LATCH_TRANSPARENT_EN for the same-cycle checks.
module tb_d_latch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       c1 = 1'b0;
    logic [0:0] d1 = '0;
    logic [0:0] q1, qb1;
    logic       c8 = 1'b0;
    logic [7:0] d8 = '0;
    logic [7:0] q8, qb8;

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    d_latch #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .C(c1), .D(d1), .Q(q1), .Qbar(qb1)
    );

    d_latch #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .C(c8), .D(d8), .Q(q8), .Qbar(qb8)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Asynchronous reset with gate open, no clk edge in between.
        #1;
        rst_n = 1'b0; c1 = 1'b1; d1 = 1'b1;
        #1;
        chk("rst_q1",    {7'd0, q1},  8'h00);
        chk("rst_qb1",   {7'd0, qb1}, 8'h01);
        chk("rst_q8",    q8,  8'h00);
        chk("rst_qb8",   qb8, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
`ifdef D_LATCH_TRANSPARENT_EN
        chk("rel_pre_q1", {7'd0, q1}, 8'h01);
`else
        chk("rel_pre_q1", {7'd0, q1}, 8'h00);
`endif
        step(1);
        chk("rel_edge_q1", {7'd0, q1}, 8'h01);

        // Gate open across several edges, then D falls.
        step(5);
        chk("trans_q1",  {7'd0, q1},  8'h01);
        chk("trans_qb1", {7'd0, qb1}, 8'h00);
        d1 = 1'b0;
        step(1);
        chk("trans_d0_q1",  {7'd0, q1},  8'h00);
        chk("trans_d0_qb1", {7'd0, qb1}, 8'h01);

        // Gate closed: D wiggles are ignored.
        c1 = 1'b0; d1 = 1'b1;
        step(5);
        chk("hold_q1", {7'd0, q1}, 8'h00);
        d1 = 1'b0;
        step(1);
        chk("hold2_q1",  {7'd0, q1},  8'h00);
        chk("hold2_qb1", {7'd0, qb1}, 8'h01);

        // Single-cycle gate captures that cycle's D.
        c1 = 1'b1; d1 = 1'b1;
        step(1);
        chk("cap_q1", {7'd0, q1}, 8'h01);
        c1 = 1'b0; d1 = 1'b0;
        step(10);
        chk("cap_hold_q1",  {7'd0, q1},  8'h01);
        chk("cap_hold_qb1", {7'd0, qb1}, 8'h00);

        // Reset pulse between edges while holding a 1.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_q1",  {7'd0, q1},  8'h00);
        chk("midrst_qb1", {7'd0, qb1}, 8'h01);
        #1;
        rst_n = 1'b1;
        step(3);
        chk("midrst_after_q1", {7'd0, q1}, 8'h00);

        // Eight-bit word.
        c8 = 1'b1; d8 = 8'hA5;
        step(1);
        chk("w8_q",  q8,  8'hA5);
        chk("w8_qb", qb8, 8'h5A);
        c8 = 1'b0; d8 = 8'hFF;
        step(3);
        chk("w8_hold_q",  q8,  8'hA5);
        chk("w8_hold_qb", qb8, 8'h5A);
        c8 = 1'b1; d8 = 8'h3C;
        #1;
`ifdef D_LATCH_TRANSPARENT_EN
        chk("w8_same_cyc", q8, 8'h3C);
`else
        chk("w8_same_cyc", q8, 8'hA5);
`endif
        step(1);
        chk("w8_next_q",  q8,  8'h3C);
        chk("w8_next_qb", qb8, 8'hC3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
